// File: rtl/count_bcd_display_if.sv
// Bundles the count input, converted BCD result and display pins of count_bcd_display.
interface count_bcd_display_if #(
  parameter int unsigned n = 4
) ();
  logic [n-1:0] count_in;
  logic [15:0]  bcd;
  logic         busy;
  logic         conv_done;
  logic [3:0]   an;
  logic [6:0]   seg;

  modport slave (
    input  count_in,
    output bcd,
    output busy,
    output conv_done,
    output an,
    output seg
  );

  modport master (
    output count_in,
    input  bcd,
    input  busy,
    input  conv_done,
    input  an,
    input  seg
  );
endinterface

// File: rtl/count_bcd_display.sv
// Binary count to BCD via sequential double-dabble, latched and shown on a
// 4-digit multiplexed active-low seven-segment display with leading-zero blanking.
module count_bcd_display #(
  parameter int unsigned n           = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               reset,
  count_bcd_display_if.slave bus
);

  localparam int unsigned BitW = (n > 1) ? $clog2(n) : 1;
  localparam int unsigned RefW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [n-1:0]    shadow_q, shadow_d;
  logic [n-1:0]    last_q, last_d;
  logic [15:0]     work_q, work_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [15:0]     work_adj;

  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    unique case (digit)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    last_d    = last_q;
    work_d    = work_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.count_in != last_q) begin
          shadow_d  = bus.count_in;
          work_d    = '0;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        work_d    = {work_adj[14:0], shadow_q[n-1]};
        // Rotate rather than shift so shadow holds the source value again after n steps.
        shadow_d  = (shadow_q << 1) | (shadow_q >> (n - 1));
        bit_cnt_d = bit_cnt_q + BitW'(1);
        if (bit_cnt_q == BitW'(n - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = work_q;
        last_d  = shadow_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A position is blank when it and every position above it hold zero.
  always_comb begin
    blank[3] = (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    blank[0] = 1'b0;
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + RefW'(1);
    idx_d     = idx_q;
    an_d      = an_q;
    seg_d     = seg_q;
    if (ref_cnt_q == RefW'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
      an_d      = ~(4'b0001 << idx_d);
      seg_d     = blank[idx_d] ? 7'h7F : seg_decode(bcd_q[{idx_d, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      last_q    <= '0;
      work_q    <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      ref_cnt_q <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= 7'h40;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      last_q    <= last_d;
      work_q    <= work_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.conv_done = (state_q == StDone);
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
- Downstream consumer of the up/down binary counter.
- Takes the counter's unsigned n-bit count and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Latches the converted digits and drives a time-multiplexed 4-digit active-low seven-segment display with leading-zero blanking.
- Sits between the counter and the board display pins.

Parameters:
- n, 4, width of count_in; legal range 1..13 so the maximum value fits in 4 BCD digits.
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  n  unsigned count from the counter.
- bcd  output  16  latched BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- busy  output  1  high while a conversion is in progress.
- conv_done  output  1  one-cycle pulse when bcd is updated.
- an  output  4  digit enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- One clock domain. Reset is synchronous and active-high; all state changes on the rising edge of clk.
- Reset values:
  - bcd=0, busy=0, conv_done=0.
  - FSM in IDLE, last converted value=0.
  - Refresh counter=0, digit index=0, an=4'b1110, seg=7'h40 (shows "0").
- Reset asserted mid-conversion aborts it; no conv_done is issued.

Conversion FSM: states IDLE, SHIFT, DONE.
- IDLE:
  - If count_in != last converted value: load shadow <= count_in, clear the 16-bit BCD work register, clear the bit counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - Each work nibble >= 5 gets +3.
  - Then shift {work, shadow} left by 1.
  - Increment the bit counter.
  - After exactly n SHIFT cycles, go to DONE.
- DONE:
  - bcd <= work, last <= shadow, conv_done=1 for this cycle only, return to IDLE.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency:
  - Change sampled in IDLE at edge k.
  - bcd updates at edge k+n+1; conv_done is high during the cycle after edge k+n.
  - Total n+2 cycles from change to visible bcd.
- count_in changes during SHIFT/DONE are ignored. The next IDLE re-compares, so the final stable value is always displayed; intermediate values may be skipped.
- count_in wrap-around (e.g. 0 -> 2^n-1 when the counter counts down) is just another value change; no special handling.
- No conversion starts from IDLE while count_in == last; in particular count_in=0 after reset triggers nothing.

Display multiplexer (runs independently of the FSM, always from the latched bcd):
- Refresh counter runs 0..REFRESH_DIV-1 and wraps.
- On the wrap cycle, digit index advances 0->1->2->3->0.
- an = ~(1 << index): index 0 = units = 4'b1110, index 3 = thousands = 4'b0111.
- seg is the registered decode of the selected nibble, updating on the same edge as an.
- Decode, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Nibbles 10..15 are unreachable and decode to 7F (blank).
- Leading-zero blanking: a digit position above the most-significant nonzero digit shows seg=7F. The units digit is never blanked.
- bcd changes take effect on the next digit slot; the current slot is not glitched mid-slot.

Test Plan:
- Reset, then hold count_in=0 for 50 cycles -> bcd=16'h0000, busy=0, conv_done never pulses, units slot seg=40, slots 1..3 seg=7F.
- n=4: step count_in 0->9 at edge k -> busy high from k+1, conv_done high exactly during the cycle after edge k+4, bcd=16'h0009 visible from k+5; units seg=10, tens blanked.
- n=4, REFRESH_DIV=4: count_in=15 -> bcd=16'h0015; an cycles 1110,1101,1011,0111 every 4 clk; seg 12 (units), 79 (tens), 7F, 7F.
- n=13: count_in=13'd8191 -> bcd=16'h8191 after 15 cycles; slots show 79, 10, 79, 00.
- n=4: count_in 3 then 7 two cycles into the conversion -> first conv_done gives bcd=0003, a second conversion follows immediately, final bcd=0007, exactly two conv_done pulses.
- Reset asserted during SHIFT -> next cycle busy=0, bcd=0000, an=1110, seg=40, no conv_done. After release, the held nonzero count_in is reconverted.
